// File: rtl/end_screen_pkg.sv
// Shared state encoding and default geometry/timing constants for the game-over screen sequencer.
package end_screen_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SLIDE_IN = 2'd1,
    SHOW     = 2'd2,
    RESTART  = 2'd3
  } end_state_t;

  localparam logic [10:0] END_START_Y        = 11'd0;
  localparam logic [10:0] END_FINAL_Y        = 11'd80;
  localparam int unsigned END_SLIDE_STEP     = 4;
  localparam int unsigned END_BLINK_FRAMES   = 16;
  localparam int unsigned END_LOCKOUT_FRAMES = 60;

endpackage

// File: rtl/end_screen_ctrl_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a 0->1 transition of din.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic prev_q;
  logic rise_q;
  logic rise_d;

  always_comb begin
    rise_d = din & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= din;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/end_screen_ctrl.sv
// Game-over screen sequencer: slide-in, blink, restart lockout and restart strobe.
// Define END_SCREEN_BLINK_EN to build the blink counter that gates endScreenDR in SHOW.
module end_screen_ctrl
  import end_screen_pkg::*;
#(
  parameter logic [10:0] START_Y        = END_START_Y,
  parameter logic [10:0] FINAL_Y        = END_FINAL_Y,
  parameter int unsigned SLIDE_STEP     = END_SLIDE_STEP,
  parameter int unsigned BLINK_FRAMES   = END_BLINK_FRAMES,
  parameter int unsigned LOCKOUT_FRAMES = END_LOCKOUT_FRAMES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        gameEnded,
  input  logic        restartKey,
  input  logic        bitmapDR,
  output logic [10:0] topLeftY,
  output logic        endScreenDR,
  output logic        freezeGame,
  output logic        restartPulse
);

  localparam logic [11:0] STEP_12  = 12'(SLIDE_STEP);
  localparam logic [11:0] FINAL_12 = {1'b0, FINAL_Y};
  localparam logic [15:0] LOCKOUT  = 16'(LOCKOUT_FRAMES);

  if (SLIDE_STEP < 1) begin : g_bad_step
    $error("SLIDE_STEP must be at least 1");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("BLINK_FRAMES must be at least 1");
  end

  logic        game_rise;
  logic        key_rise;
  end_state_t  state_q, state_d;
  logic [10:0] top_y_q, top_y_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        freeze_q, freeze_d;
  logic        pulse_q, pulse_d;
  logic [11:0] slide_next;
  logic        phase;

  rise_detect u_game_rise (
    .clk   (clk),
    .reset (reset),
    .din   (gameEnded),
    .rise  (game_rise)
  );

  rise_detect u_key_rise (
    .clk   (clk),
    .reset (reset),
    .din   (restartKey),
    .rise  (key_rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      top_y_q     <= START_Y;
      frame_cnt_q <= '0;
      freeze_q    <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      top_y_q     <= top_y_d;
      frame_cnt_q <= frame_cnt_d;
      freeze_q    <= freeze_d;
      pulse_q     <= pulse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    top_y_d     = top_y_q;
    frame_cnt_d = frame_cnt_q;
    // 12-bit sum so a step past 2047 cannot wrap below FINAL_Y
    slide_next  = {1'b0, top_y_q} + STEP_12;
    case (state_q)
      IDLE: begin
        top_y_d     = START_Y;
        frame_cnt_d = '0;
        if (game_rise) state_d = SLIDE_IN;
      end
      SLIDE_IN: begin
        if (startOfFrame) begin
          if (slide_next >= FINAL_12) begin
            top_y_d     = FINAL_Y;
            frame_cnt_d = '0;
            state_d     = SHOW;
          end else begin
            top_y_d = slide_next[10:0];
          end
        end
      end
      SHOW: begin
        if (startOfFrame && (frame_cnt_q != LOCKOUT)) frame_cnt_d = frame_cnt_q + 16'd1;
        if ((frame_cnt_q == LOCKOUT) && key_rise) state_d = RESTART;
      end
      RESTART: begin
        top_y_d = START_Y;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    freeze_d    = (state_d != IDLE);
    pulse_d     = (state_d == RESTART);
    endScreenDR = 1'b0;
    case (state_q)
      SLIDE_IN: endScreenDR = bitmapDR;
      SHOW:     endScreenDR = bitmapDR & phase;
      default:  endScreenDR = 1'b0;
    endcase
  end

`ifdef END_SCREEN_BLINK_EN
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;

  // Every SHOW visit starts visible with a fresh half-period.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (state_q != SHOW) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (startOfFrame) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign phase = phase_q;
`else
  assign phase = 1'b1;
`endif

  assign topLeftY     = top_y_q;
  assign freezeGame   = freeze_q;
  assign restartPulse = pulse_q;

endmodule

// File: tb/tb_end_screen_ctrl.sv
// Directed bench for end_screen_ctrl: slide-in, blink, lockout, restart, retrigger and reset.
module tb_end_screen_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic        gameEnded;
  logic        restartKey;
  logic        bitmapDR;
  logic [10:0] topLeftY;
  logic        endScreenDR;
  logic        freezeGame;
  logic        restartPulse;

  int checks = 0;
  int failures = 0;
  int pulse_seen = 0;

  always #5 clk = ~clk;

  end_screen_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .gameEnded    (gameEnded),
    .restartKey   (restartKey),
    .bitmapDR     (bitmapDR),
    .topLeftY     (topLeftY),
    .endScreenDR  (endScreenDR),
    .freezeGame   (freezeGame),
    .restartPulse (restartPulse)
  );

  always @(negedge clk) if (restartPulse === 1'b1) pulse_seen++;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One video frame: a single-cycle startOfFrame followed by two quiet cycles.
  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    tick();
  endtask

  function automatic int exp_blink(input int f);
`ifdef END_SCREEN_BLINK_EN
    return ((f / 16) % 2 == 0) ? 1 : 0;
`else
    return (f >= 0) ? 1 : 0;
`endif
  endfunction

  initial begin
    reset = 1'b1;
    startOfFrame = 1'b0;
    gameEnded = 1'b0;
    restartKey = 1'b0;
    bitmapDR = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_val("rst_y", int'(topLeftY), 0);
    check_val("rst_freeze", int'(freezeGame), 0);
    check_val("rst_pulse", int'(restartPulse), 0);
    check_val("rst_dr", int'(endScreenDR), 0);
    repeat (5) tick();

    gameEnded = 1'b1;
    tick();
    check_val("freeze_lat1", int'(freezeGame), 0);
    tick();
    check_val("freeze_lat2", int'(freezeGame), 1);
    check_val("slide_dr_on", int'(endScreenDR), 1);
    bitmapDR = 1'b0;
    #1;
    check_val("slide_dr_off", int'(endScreenDR), 0);
    bitmapDR = 1'b1;

    for (int k = 1; k <= 20; k++) begin
      frame();
      check_val($sformatf("slide_y%0d", k), int'(topLeftY), 4 * k);
    end
    check_val("show_freeze", int'(freezeGame), 1);

    for (int f = 1; f <= 70; f++) begin
      frame();
      check_val($sformatf("blink_f%0d", f), int'(endScreenDR), exp_blink(f));
      if (f == 30) restartKey = 1'b1;
      if (f == 65) restartKey = 1'b0;
    end
    check_val("show_y", int'(topLeftY), 80);
    check_val("lockout_no_pulse", pulse_seen, 0);

    restartKey = 1'b1;
    tick();
    check_val("key_lat1", int'(restartPulse), 0);
    tick();
    check_val("key_lat2", int'(restartPulse), 1);
    check_val("restart_freeze", int'(freezeGame), 1);
    tick();
    check_val("after_pulse", int'(restartPulse), 0);
    check_val("idle_freeze", int'(freezeGame), 0);
    check_val("idle_y", int'(topLeftY), 0);
    check_val("idle_dr", int'(endScreenDR), 0);
    restartKey = 1'b0;

    repeat (3) frame();
    check_val("held_y", int'(topLeftY), 0);
    check_val("held_freeze", int'(freezeGame), 0);

    gameEnded = 1'b0;
    tick();
    tick();
    gameEnded = 1'b1;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check_val("coinc_freeze1", int'(freezeGame), 0);
    tick();
    check_val("coinc_freeze2", int'(freezeGame), 1);
    check_val("coinc_y0", int'(topLeftY), 0);
    frame();
    check_val("coinc_y4", int'(topLeftY), 4);
    repeat (9) frame();
    check_val("pre_rst_y", int'(topLeftY), 40);

    reset = 1'b1;
    tick();
    check_val("midrst_y", int'(topLeftY), 0);
    check_val("midrst_freeze", int'(freezeGame), 0);
    check_val("midrst_pulse", int'(restartPulse), 0);
    check_val("midrst_dr", int'(endScreenDR), 0);
    reset = 1'b0;
    tick();
    check_val("total_pulses", pulse_seen, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
